// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: datapath width default,
// ALU op codes and the arbiter FSM state encoding.
package alu_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SRA = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: eight ops, zero/negative flags and unsigned borrow on sub.
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      ctrl,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            neg,
  output logic            neg_u
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    result = '0;
    neg_u  = 1'b0;
    case (alu_op_e'(ctrl))
      ALU_ADD: result = a + b;
      ALU_SUB: begin
        result = a - b;
        neg_u  = (a < b);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SRA: result = $signed(a) >>> shamt;
      ALU_SRL: result = a >> shamt;
      ALU_SLL: result = a << shamt;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign neg  = result[XLEN-1];

endmodule

// File: rtl/alu_rr_pick.sv
// Round-robin picker: one-hot grant to the first set request after ptr,
// wrapping modulo N_REQ. Purely combinational.
module alu_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDXW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDXW-1:0]  ptr,
  output logic [N_REQ-1:0] grant
);

  logic [IDXW-1:0] idx;
  logic            found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = IDXW'((int'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among N_REQ requesters with round-robin arbitration.
// Optional response counter on o_op_count enabled by ALU_ARBITER_STATS_EN.
//
// state   | meaning
// IDLE    | offer ready to round-robin winner, capture operands on handshake
// EXEC    | ALU evaluates captured operands, result/flags registered
// RESP    | o_rsp_valid high, outputs held until i_rsp_ready
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int N_REQ = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_req_valid,
  output logic [N_REQ-1:0]          o_req_ready,
  input  logic [N_REQ*XLEN-1:0]     i_req_a,
  input  logic [N_REQ*XLEN-1:0]     i_req_b,
  input  logic [N_REQ*3-1:0]        i_req_ctrl,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [$clog2(N_REQ)-1:0]  o_rsp_id,
  output logic [XLEN-1:0]           o_rsp_result,
  output logic                      o_rsp_zero,
  output logic                      o_rsp_neg,
  output logic                      o_rsp_negU,
  output logic                      o_busy,
  output logic [15:0]               o_op_count
);

  localparam int IDXW = $clog2(N_REQ);

  arb_state_e       state, state_nxt;
  logic [IDXW-1:0]  ptr;
  logic [N_REQ-1:0] grant;
  logic             accept, rsp_fire;

  logic [XLEN-1:0]  sel_a, sel_b, op_a, op_b;
  logic [2:0]       sel_ctrl, op_ctrl;
  logic [IDXW-1:0]  sel_id, op_id, rsp_id;

  logic [XLEN-1:0]  alu_result, rsp_result;
  logic             alu_zero, alu_neg, alu_neg_u;
  logic             rsp_zero, rsp_neg, rsp_neg_u;

  alu_rr_pick #(.N_REQ(N_REQ), .IDXW(IDXW)) u_pick (
    .req   (i_req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  alu #(.XLEN(XLEN)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .ctrl   (op_ctrl),
    .result (alu_result),
    .zero   (alu_zero),
    .neg    (alu_neg),
    .neg_u  (alu_neg_u)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_req_ready = '0;
    o_rsp_valid = 1'b0;
    o_busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        o_busy      = 1'b0;
        o_req_ready = grant;
        if (|grant) state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept   = |(o_req_ready & i_req_valid);
  assign rsp_fire = o_rsp_valid & i_rsp_ready;

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_ctrl = '0;
    sel_id   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        sel_a    = i_req_a[k*XLEN +: XLEN];
        sel_b    = i_req_b[k*XLEN +: XLEN];
        sel_ctrl = i_req_ctrl[k*3 +: 3];
        sel_id   = IDXW'(k);
      end
    end
  end

  // Pointer resets to the last index so requester 0 wins the first search.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr        <= IDXW'(N_REQ - 1);
      op_a       <= '0;
      op_b       <= '0;
      op_ctrl    <= '0;
      op_id      <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_neg    <= 1'b0;
      rsp_neg_u  <= 1'b0;
      rsp_id     <= '0;
    end else begin
      if (accept) begin
        op_a    <= sel_a;
        op_b    <= sel_b;
        op_ctrl <= sel_ctrl;
        op_id   <= sel_id;
        ptr     <= sel_id;
      end
      if (state == ST_EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_neg    <= alu_neg;
        rsp_neg_u  <= alu_neg_u;
        rsp_id     <= op_id;
      end
    end
  end

  assign o_rsp_result = rsp_result;
  assign o_rsp_zero   = rsp_zero;
  assign o_rsp_neg    = rsp_neg;
  assign o_rsp_negU   = rsp_neg_u;
  assign o_rsp_id     = rsp_id;

`ifdef ALU_ARBITER_STATS_EN
  logic [15:0] op_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      op_count <= '0;
    else if (rsp_fire) op_count <= op_count + 16'd1;
  end

  assign o_op_count = op_count;
`else
  assign o_op_count = '0;
`endif

endmodule
